if_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register.
//  - Owns the PC and drives a single-outstanding-request instruction-memory handshake.
//  - Applies redirects (branch, j/jal, jr) resolved in ID; honours ID stall.
//  - Presents Instruction_D / PC_D / PC_plus4_D / valid_D to the decode stage.

---
 rtl/if_stage.sv | 142 ++++++++++++++
 tb/tb_if_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a single-outstanding imem handshake,
// ID-resolved redirects (branch / j / jr) and the IF/ID pipeline register.
// A one-word skid buffer holds a word that returns while ID is stalled.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_D,
    input  logic        branch_taken_D,
    input  logic [31:0] branch_target_D,
    input  logic        jump_D,
    input  logic [25:0] Low26_D,
    input  logic        jr_D,
    input  logic [31:0] jr_target_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_plus4_D,
    output logic        valid_D
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]  state;
    logic [31:0] skid;
    logic        pend_vld;
    logic [31:0] pend_pc;

    logic        ack;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] next_pc;

    // An ack only counts against a live request; a late ack after reset is dropped.
    assign ack = imem_ack & imem_req;

    // Redirect decode: only while ID is not stalled, jr > jump > branch.
    always_comb begin
        redir = !stall_D && (jr_D || jump_D || branch_taken_D);
        if (jr_D)
            tgt = {jr_target_D[31:2], 2'b00};
        else if (jump_D)
            tgt = {PC_plus4_D[31:28], Low26_D, 2'b00};
        else
            tgt = branch_target_D;
    end

    // Sequential fall-through address, unless a redirect was recorded mid-wait.
    assign next_pc = pend_vld ? pend_pc : imem_addr + 32'd4;

    // Fetch FSM, PC, pending target, skid buffer and IF/ID register.
    // While in HOLD imem_addr still names the buffered word; it advances on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_FETCH;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            skid          <= 32'h0;
            pend_vld      <= 1'b0;
            pend_pc       <= 32'h0;
            Instruction_D <= 32'h0;
            PC_D          <= 32'h0;
            PC_plus4_D    <= 32'h0;
            valid_D       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (ack && !stall_D) begin
                        if (redir && !DELAY_SLOT) begin
                            valid_D       <= 1'b0;
                            Instruction_D <= 32'h0;
                        end else begin
                            Instruction_D <= imem_rdata;
                            PC_D          <= imem_addr;
                            PC_plus4_D    <= imem_addr + 32'd4;
                            valid_D       <= 1'b1;
                        end
                        imem_addr <= redir ? tgt : next_pc;
                        pend_vld  <= 1'b0;
                    end else if (ack) begin
                        skid     <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_HOLD;
                    end else if (!stall_D) begin
                        valid_D       <= 1'b0;
                        Instruction_D <= 32'h0;
                        if (redir) begin
                            pend_vld <= 1'b1;
                            pend_pc  <= tgt;
                            if (!DELAY_SLOT)
                                state <= S_DROP;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_D) begin
                        if (redir && !DELAY_SLOT) begin
                            valid_D       <= 1'b0;
                            Instruction_D <= 32'h0;
                        end else begin
                            Instruction_D <= skid;
                            PC_D          <= imem_addr;
                            PC_plus4_D    <= imem_addr + 32'd4;
                            valid_D       <= 1'b1;
                        end
                        imem_addr <= redir ? tgt : next_pc;
                        pend_vld  <= 1'b0;
                        imem_req  <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_DROP: begin
                    imem_req <= 1'b1;
                    if (!stall_D) begin
                        valid_D       <= 1'b0;
                        Instruction_D <= 32'h0;
                        if (redir) begin
                            pend_vld <= 1'b1;
                            pend_pc  <= tgt;
                        end
                    end
                    // Squashed word returns: discard it and go to the recorded target.
                    if (ack) begin
                        imem_addr <= redir ? tgt : next_pc;
                        pend_vld  <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vectors for if_stage. u_ds1 uses the delay slot,
// u_ds0 squashes it; each has its own wait-state memory model.
module tb_if_stage;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_D, branch_taken_D, jump_D, jr_D;
    logic [31:0] branch_target_D, jr_target_D;
    logic [25:0] Low26_D;
    logic [1:0]  wait_n;

    logic        req0, ack0, v0, req1, ack1, v1;
    logic [31:0] addr0, rd0, ins0, pc0, p40, addr1, rd1, ins1, pc1, p41;
    logic [1:0]  cnt0, cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Memory models: ack after wait_n cycles of a held request.
    assign ack0 = req0 && (cnt0 == wait_n);
    assign ack1 = req1 && (cnt1 == wait_n);
    assign rd0  = addr0 ^ MASK;
    assign rd1  = addr1 ^ MASK;

    always @(posedge clk) begin
        cnt0 <= (!req0 || ack0) ? 2'd0 : cnt0 + 2'd1;
        cnt1 <= (!req1 || ack1) ? 2'd0 : cnt1 + 2'd1;
    end

    if_stage u_ds1 (
        .clk(clk), .rst(rst), .stall_D(stall_D),
        .branch_taken_D(branch_taken_D), .branch_target_D(branch_target_D),
        .jump_D(jump_D), .Low26_D(Low26_D), .jr_D(jr_D), .jr_target_D(jr_target_D),
        .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0), .imem_rdata(rd0),
        .Instruction_D(ins0), .PC_D(pc0), .PC_plus4_D(p40), .valid_D(v0)
    );

    if_stage #(.DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .rst(rst), .stall_D(stall_D),
        .branch_taken_D(branch_taken_D), .branch_target_D(branch_target_D),
        .jump_D(jump_D), .Low26_D(Low26_D), .jr_D(jr_D), .jr_target_D(jr_target_D),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rd1),
        .Instruction_D(ins1), .PC_D(pc1), .PC_plus4_D(p41), .valid_D(v1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        stall_D = 0; branch_taken_D = 0; jump_D = 0; jr_D = 0;
        branch_target_D = 0; jr_target_D = 0; Low26_D = 0; wait_n = 2'd0;

        // 1: reset and zero-wait streaming
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", {31'b0, req0}, 32'h0);
        chk("rst_addr", addr0, 32'h3000);
        chk("rst_valid", {31'b0, v0}, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_ins", ins0, 32'h0);
        chk("rst_p4", p40, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_req", {31'b0, req0}, 32'h1);
        chk("t1_addr0", addr0, 32'h3000);
        chk("t1_v0", {31'b0, v0}, 32'h0);
        @(negedge clk);
        chk("t1_v1", {31'b0, v0}, 32'h1);
        chk("t1_pc", pc0, 32'h3000);
        chk("t1_ins", ins0, 32'h3000 ^ MASK);
        chk("t1_p4", p40, 32'h3004);
        chk("t1_addr1", addr0, 32'h3004);
        @(negedge clk);
        chk("t1_pc2", pc0, 32'h3004);
        chk("t1_addr2", addr0, 32'h3008);

        // 2: two wait states
        wait_n = 2'd2;
        @(negedge clk);
        chk("t2_bub_v", {31'b0, v0}, 32'h0);
        chk("t2_bub_ins", ins0, 32'h0);
        chk("t2_pc_hold", pc0, 32'h3004);
        chk("t2_addr_a", addr0, 32'h3008);
        chk("t2_req_a", {31'b0, req0}, 32'h1);
        @(negedge clk);
        chk("t2_addr_b", addr0, 32'h3008);
        chk("t2_v_b", {31'b0, v0}, 32'h0);
        @(negedge clk);
        chk("t2_v_c", {31'b0, v0}, 32'h1);
        chk("t2_pc_c", pc0, 32'h3008);
        chk("t2_addr_c", addr0, 32'h300C);

        // 3: stall over the ack -> HOLD, then buffered word delivered
        wait_n = 2'd0;
        stall_D = 1'b1;
        @(negedge clk);
        chk("t3_req_a", {31'b0, req0}, 32'h0);
        chk("t3_pc_a", pc0, 32'h3008);
        @(negedge clk);
        chk("t3_req_b", {31'b0, req0}, 32'h0);
        chk("t3_ins_b", ins0, 32'h3008 ^ MASK);
        @(negedge clk);
        chk("t3_pc_c", pc0, 32'h3008);
        chk("t3_v_c", {31'b0, v0}, 32'h1);
        stall_D = 1'b0;
        @(negedge clk);
        chk("t3_pc_d", pc0, 32'h300C);
        chk("t3_ins_d", ins0, 32'h300C ^ MASK);
        chk("t3_req_d", {31'b0, req0}, 32'h1);
        chk("t3_addr_d", addr0, 32'h3010);

        // 4: DS=1 taken branch at 3000 -> 3100; then again mid-wait via pending
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("t4_pc_br", pc0, 32'h3000);
        branch_taken_D = 1'b1; branch_target_D = 32'h3100;
        @(negedge clk);
        branch_taken_D = 1'b0;
        chk("t4_slot_pc", pc0, 32'h3004);
        chk("t4_slot_v", {31'b0, v0}, 32'h1);
        chk("t4_addr_t", addr0, 32'h3100);
        @(negedge clk);
        chk("t4_pc_t", pc0, 32'h3100);
        chk("t4_addr_n", addr0, 32'h3104);
        wait_n = 2'd2;
        branch_taken_D = 1'b1; branch_target_D = 32'h3200;
        @(negedge clk);
        branch_taken_D = 1'b0;
        chk("t4_pend_v", {31'b0, v0}, 32'h0);
        chk("t4_pend_addr", addr0, 32'h3104);
        @(negedge clk);
        chk("t4_pend_addr2", addr0, 32'h3104);
        @(negedge clk);
        chk("t4_pend_slot", pc0, 32'h3104);
        chk("t4_pend_slot_v", {31'b0, v0}, 32'h1);
        chk("t4_pend_tgt", addr0, 32'h3200);

        // 5: DS=0, j 0xC40 at 3000 mid-wait -> DROP, stale 3004 discarded, fetch 3100
        wait_n = 2'd0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("t5_pc_j", pc1, 32'h3000);
        wait_n = 2'd2;
        jump_D = 1'b1; Low26_D = 26'h0000C40;
        @(negedge clk);
        jump_D = 1'b0;
        chk("t5_drop_v", {31'b0, v1}, 32'h0);
        chk("t5_drop_addr", addr1, 32'h3004);
        chk("t5_drop_req", {31'b0, req1}, 32'h1);
        @(negedge clk);
        chk("t5_drop_addr2", addr1, 32'h3004);
        @(negedge clk);
        chk("t5_tgt_addr", addr1, 32'h3100);
        chk("t5_tgt_v", {31'b0, v1}, 32'h0);
        chk("t5_tgt_ins", ins1, 32'h0);
        wait_n = 2'd0;
        @(negedge clk);
        chk("t5_pc_t", pc1, 32'h3100);
        chk("t5_ins_t", ins1, 32'h3100 ^ MASK);
        chk("t5_v_t", {31'b0, v1}, 32'h1);

        // 6: redirect ignored under stall; jr beats jump, low bits cleared
        do_reset();
        @(negedge clk);
        @(negedge clk);
        stall_D = 1'b1; jr_D = 1'b1; jump_D = 1'b1;
        jr_target_D = 32'h3203; Low26_D = 26'h0000C40;
        @(negedge clk);
        chk("t6_stall_req", {31'b0, req0}, 32'h0);
        chk("t6_stall_pc", pc0, 32'h3000);
        stall_D = 1'b0; jr_D = 1'b0; jump_D = 1'b0;
        @(negedge clk);
        chk("t6_noredir_pc", pc0, 32'h3004);
        chk("t6_noredir_addr", addr0, 32'h3008);
        jr_D = 1'b1; jump_D = 1'b1;
        @(negedge clk);
        jr_D = 1'b0; jump_D = 1'b0;
        chk("t6_slot_pc", pc0, 32'h3008);
        chk("t6_jr_addr", addr0, 32'h3200);
        @(negedge clk);
        chk("t6_pc_t", pc0, 32'h3200);
        chk("t6_p4_t", p40, 32'h3204);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
